// File: rtl/vp_pkg.sv
// Shared definitions for the vector result path: default widths, accumulator
// FSM states and a width-generic sign-extension helper.
package vp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // Sign-extends the low from_w bits of value to 64 bits (from_w in 1..64).
    function automatic logic [63:0] sign_extend(input logic [63:0] value,
                                                input logic [6:0]  from_w);
        logic [6:0]         sh;
        logic signed [63:0] shifted;
        sh      = 7'd64 - from_w;
        shifted = $signed(value << sh);
        return shifted >>> sh;
    endfunction

endpackage

// File: rtl/vp_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head reads as zero when empty.
module vp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_data  = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

    // Storage write port (contents deliberately not reset).
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vector_result_buffer.sv
// Captures reduced dot-product results, optionally accumulates partial sums,
// and queues finished values for a consumer behind a valid/ready handshake.
module vector_result_buffer
    import vp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       save_c,
    input  logic [DATA_W-1:0]          c_in,
    input  logic                       acc_mode,
    input  logic                       c_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] w_c_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_push;
    logic [ACC_W-1:0] w_push_data;
    logic             w_pop;
    logic             w_drop;
    logic             r_overflow;

    assign w_c_ext = ACC_W'(sign_extend(64'(c_in), 7'(DATA_W)));
    assign w_sum   = r_acc + w_c_ext;

    // Accumulator FSM: next state, next accumulator value and push request.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_push      = 1'b0;
        w_push_data = w_c_ext;
        case (r_state)
            IDLE: begin
                w_acc_nxt = {ACC_W{1'b0}};
                if (save_c) begin
                    if (!acc_mode || c_last) begin
                        w_push = 1'b1;
                    end else begin
                        w_acc_nxt   = w_c_ext;
                        w_state_nxt = ACCUM;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCUM: begin
                if (save_c) begin
                    if (c_last) begin
                        w_push      = 1'b1;
                        w_push_data = w_sum;
                        w_acc_nxt   = {ACC_W{1'b0}};
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_sum;
                    end
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_acc_nxt   = {ACC_W{1'b0}};
            end
        endcase
    end

    // FSM state and running sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_acc   <= {ACC_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    assign w_pop  = out_valid & out_ready;
    assign w_drop = w_push & full & ~w_pop;

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign overflow  = r_overflow;
    assign out_valid = ~empty;

    vp_sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

endmodule

// File: doc/vector_result_buffer.md
# vector_result_buffer

Downstream stage of the dot-product pipeline controller: captures the lane-reduced result `c_in` on each `save_c` pulse, optionally accumulates successive partial results into one wide sum, and queues finished values in a small FIFO. Queued values drain to the consumer over a valid/ready handshake. This decouples the fixed-cadence controller schedule from a consumer that may stall.

## Interface
- `DATA_W`, 16: width of `c_in` (two's complement).
- `ACC_W`, 32: width of accumulator and `out_data`; must be ≥ `DATA_W`.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `save_c`  in  1  one-cycle strobe from the controller: `c_in` is valid this cycle.
- `c_in`  in  DATA_W  reduced result from adder stage 2.
- `acc_mode`  in  1  1 = accumulate across strobes; 0 = each strobe is a final value.
- `c_last`  in  1  with `save_c` in accumulate mode, closes the running sum.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_data`  out  ACC_W  FIFO head; all zeros when empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`, `empty`  out  1 each  occupancy flags.
- `overflow`  out  1  sticky: a push was dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Accumulator FSM, states `IDLE`/`ACCUM`, with register `acc` of width ACC_W.
- `IDLE`: `acc` = 0. On `save_c`:
  - `acc_mode`=0, or `acc_mode`=1 with `c_last`=1: push sext(`c_in`); stay in `IDLE`.
  - `acc_mode`=1 with `c_last`=0: `acc` ← sext(`c_in`); go to `ACCUM`.
- `ACCUM`: `acc_mode` is ignored.
  - `save_c` with `c_last`=0: `acc` ← `acc` + sext(`c_in`).
  - `save_c` with `c_last`=1: push `acc` + sext(`c_in`), clear `acc`, go to `IDLE`.
- Arithmetic: sign-extend `c_in` to ACC_W; addition wraps modulo 2^ACC_W; no saturation.
- Push when `full` and no pop in the same cycle: data is dropped, `overflow` ← 1. FSM still returns to `IDLE` and `acc` still clears.
- Pop occurs when `out_valid & out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop: both occur and `count` is unchanged. When `full`, the pop frees the slot and there is no overflow.
- `clear_ovf` together with a new overflow event: the set wins.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - FSM=`IDLE`, `acc`=0, pointers=0.
  - FIFO storage is not reset.
- Push latency: a `save_c` sampled at edge N gives `out_valid`=1 and `out_data` = the value from edge N onward (1 cycle).
- `out_data`, `out_valid`, `full`, `empty`, and `count` are all derived from registered state only; there is no combinational path from any input.
- Pop latency: a pop at edge N presents the next entry, or `out_valid`=0, after edge N.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-accumulation or with the FIFO non-empty: all state returns to reset values immediately (asynchronously). The partial sum and queued data are lost, and no pop is reported.
- Reset deassertion is synchronised externally; the block first acts on the edge after `rst` rises.

## Structure
- Shared package `vp_pkg`:
  - default `DATA_W`/`ACC_W` constants;
  - `acc_state_t` enum (`IDLE`, `ACCUM`);
  - a sign-extension function.
- Sub-module `vp_sync_fifo` (parameters: width, depth) holds storage, pointers, `count`, `full`, and `empty`.
- The top level contains the FSM, the accumulator, and the overflow logic.

## Test plan
- Non-accumulate mode:
  - Stimulus: `acc_mode`=0; `save_c` with `c_in`=5, then -3 (16'hFFFD); `out_ready`=1.
  - Required: `out_data`=32'd5, then 32'hFFFF_FFFD, each valid for one cycle; `empty`=1 afterwards.
- Accumulate mode:
  - Stimulus: `acc_mode`=1; strobes with 100, 200, and −50 (the last with `c_last`=1); `out_ready`=0.
  - Required: exactly one entry, `out_data`=250, `count`=1.
- Overflow:
  - Stimulus: `out_ready`=0; 5 strobes with values 1 to 5.
  - Required: `full`=1, `count`=4, `overflow`=1; draining yields 1,2,3,4.
  - Then `clear_ovf`: `overflow`=0.
- Push and pop at full:
  - Stimulus: FIFO full; `save_c` with 9 and `out_ready`=1 in the same cycle.
  - Required: `count` stays 4, `overflow` stays 0, and 9 emerges last.
- Reset mid-operation:
  - Stimulus: in `ACCUM` with `acc`=300 and 2 entries queued, pulse `rst`=0 between clock edges.
  - Required: outputs reach reset values immediately. A subsequent single non-accumulate strobe of 7 yields `out_data`=7.
- Wrap: 3×DEPTH push/pop pairs with an incrementing pattern; outputs keep their order with no loss.
